// File: rtl/writeback_pkg.sv
// Shared encodings for the writeback stage:
// source select codes and NZP condition-code values.
package writeback_pkg;

   localparam logic [1:0] WB_SRC_ALU     = 2'h0;
   localparam logic [1:0] WB_SRC_MEM     = 2'h1;
   localparam logic [1:0] WB_SRC_PC      = 2'h2;
   localparam logic [1:0] WB_SRC_ILLEGAL = 2'h3;

   localparam logic [2:0] NZP_N     = 3'b100;
   localparam logic [2:0] NZP_Z     = 3'b010;
   localparam logic [2:0] NZP_P     = 3'b001;
   localparam logic [2:0] NZP_RESET = NZP_Z;

endpackage

// File: rtl/wb_reg_array.sv
// Register file: one write port, two async read ports,
// optional same-cycle write-to-read bypass.
module wb_reg_array #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 3,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr1,
   input  logic [ADDR_W-1:0] i_raddr2,
   output logic [DATA_W-1:0] o_rdata1,
   output logic [DATA_W-1:0] o_rdata2
);

   localparam logic [ADDR_W:0] NR = NUM_REGS[ADDR_W:0];

   logic [DATA_W-1:0] r_mem [NUM_REGS];

   // Storage: cleared asynchronously, written on a legal commit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read port 1: out-of-range reads 0, bypass when enabled
   always_comb begin
      o_rdata1 = '0;
      if ({1'b0, i_raddr1} < NR) begin
         if (BYPASS && i_we && (i_raddr1 == i_waddr))
            o_rdata1 = i_wdata;
         else
            o_rdata1 = r_mem[i_raddr1];
      end
   end

   // Read port 2: same behaviour as port 1
   always_comb begin
      o_rdata2 = '0;
      if ({1'b0, i_raddr2} < NR) begin
         if (BYPASS && i_we && (i_raddr2 == i_waddr))
            o_rdata2 = i_wdata;
         else
            o_rdata2 = r_mem[i_raddr2];
      end
   end

endmodule

// File: rtl/writeback_rf_sb.sv
// Writeback stage: source mux, register commit, NZP update
// and a pending-destination scoreboard for decode stalls.
module writeback_rf_sb
   import writeback_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 3,
   parameter bit BYPASS   = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable_writeback,
   input  logic [1:0]          W_Control,
   input  logic [DATA_W-1:0]   aluout,
   input  logic [DATA_W-1:0]   memout,
   input  logic [DATA_W-1:0]   pcout,
   input  logic [ADDR_W-1:0]   dr,
   input  logic                cc_en,
   input  logic [ADDR_W-1:0]   sr1,
   input  logic [ADDR_W-1:0]   sr2,
   output logic [DATA_W-1:0]   VSR1,
   output logic [DATA_W-1:0]   VSR2,
   input  logic                claim_valid,
   input  logic [ADDR_W-1:0]   claim_dr,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic                sr1_busy,
   output logic                sr2_busy,
   output logic [2:0]          nzp,
   output logic                err
);

   localparam logic [ADDR_W:0] NR = NUM_REGS[ADDR_W:0];

   logic [DATA_W-1:0]   w_dr_in;
   logic                w_dr_ok;
   logic                w_src_ok;
   logic                w_commit;
   logic                w_illegal;
   logic                w_claim;
   logic [2:0]          w_nzp_new;
   logic [NUM_REGS-1:0] w_busy_nxt;
   logic [NUM_REGS-1:0] r_busy;
   logic [2:0]          r_nzp;
   logic                r_err;

   assign w_dr_ok   = ({1'b0, dr} < NR);
   assign w_src_ok  = (W_Control != WB_SRC_ILLEGAL);
   assign w_commit  = enable_writeback & w_src_ok & w_dr_ok;
   assign w_illegal = enable_writeback & ~(w_src_ok & w_dr_ok);
   assign w_claim   = claim_valid & ({1'b0, claim_dr} < NR);

   // Writeback source select
   always_comb begin
      w_dr_in = '0;
      case (W_Control)
         WB_SRC_ALU: w_dr_in = aluout;
         WB_SRC_MEM: w_dr_in = memout;
         WB_SRC_PC:  w_dr_in = pcout;
         default:    w_dr_in = '0;
      endcase
   end

   // Condition code derived from the committed value
   always_comb begin
      w_nzp_new = NZP_P;
      if (w_dr_in[DATA_W-1])  w_nzp_new = NZP_N;
      else if (w_dr_in == '0) w_nzp_new = NZP_Z;
   end

   // Next scoreboard: commit clears, then a claim re-sets
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_commit) w_busy_nxt[dr] = 1'b0;
      if (w_claim)  w_busy_nxt[claim_dr] = 1'b1;
   end

   // Scoreboard, condition codes and sticky error state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy <= '0;
         r_nzp  <= NZP_RESET;
         r_err  <= 1'b0;
      end else begin
         r_busy <= w_busy_nxt;
         if (w_commit && cc_en) r_nzp <= w_nzp_new;
         if (w_illegal) r_err <= 1'b1;
      end
   end

   // Hazard report includes a claim arriving this cycle
   always_comb begin
      sr1_busy = w_claim & (claim_dr == sr1);
      sr2_busy = w_claim & (claim_dr == sr2);
      if ({1'b0, sr1} < NR) sr1_busy = sr1_busy | r_busy[sr1];
      if ({1'b0, sr2} < NR) sr2_busy = sr2_busy | r_busy[sr2];
   end

   assign busy_vec = r_busy;
   assign nzp      = r_nzp;
   assign err      = r_err;

   wb_reg_array #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .BYPASS   (BYPASS)
   ) u_rf (
      .clk      (clk),
      .rst      (rst),
      .i_we     (w_commit),
      .i_waddr  (dr),
      .i_wdata  (w_dr_in),
      .i_raddr1 (sr1),
      .i_raddr2 (sr2),
      .o_rdata1 (VSR1),
      .o_rdata2 (VSR2)
   );

endmodule
